bcd_scan4: RTL
==============

BCD_SCAN4 -- requirements
Module: bcd_scan4

Interface
REQ-001 SHALL provide parameter PRESCALE, default 4, clock cycles each digit is displayed (legal range 1..65535).
REQ-002 SHALL provide CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide CDN  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide LD  input  1  load strobe; samples D into holding register.
REQ-005 SHALL provide D  input  16  four BCD digits from upstream decade counters; D[3:0] digit 0 (least significant) ... D[15:12] digit 3.
REQ-006 SHALL provide BLANK_EN  input  1  leading-zero blanking enable.
REQ-007 SHALL provide SEG  output  7  segment drive, active-high, SEG[0]=a ... SEG[6]=g.
REQ-008 SHALL provide AN  output  4  digit select, active-high, one-hot or all-zero.
REQ-009 SHALL provide ERR  output  1  high while the held value contains a non-BCD nibble.
REQ-010 SHALL provide FRAME  output  1  one-cycle pulse at end of each full 4-digit scan.

Function
REQ-011 SHALL hold a 16-bit register H; on an edge with LD=1, H<=D; otherwise H holds.
REQ-012 SHALL update ERR on every load: ERR<=1 if any nibble of D >9, else 0; ERR holds between loads.
REQ-013 SHALL keep prescale counter PC (0..PRESCALE-1) incrementing every cycle, wrapping to 0 after PRESCALE-1.
REQ-014 SHALL keep digit index DI (0..3), advancing 0->1->2->3->0 on the edge where PC==PRESCALE-1; with PRESCALE=1, DI advances every cycle.
REQ-015 SHALL drive FRAME=1 for exactly the cycle after the edge where PC==PRESCALE-1 and DI==3 (registered), else 0.
REQ-016 SHALL register SEG and AN: at each edge AN<=onehot(DI) and SEG<=decode(H nibble DI), using DI and H values before that edge.
REQ-017 SHALL decode 0..9 to SEG hex 3F,06,5B,4F,66,6D,7D,07,7F,6F; nibbles A..F to 40 (dash, g only).
REQ-018 SHALL blank (SEG=00, AN still asserted) digit n (n=1..3) when BLANK_EN=1, nibble n==0, and all nibbles above n ==0; digit 0 is never blanked.
REQ-019 SHALL NOT let LD disturb PC or DI; a load mid-scan takes effect on the next digit output computed from H.
REQ-020 SHALL show newly loaded data on SEG no earlier than the second edge after the LD edge (load edge + output register edge).
REQ-021 SHALL treat BLANK_EN as live (not latched), affecting the next registered SEG value.

Reset
REQ-022 SHALL, on any edge with CDN=0, set H=0000, PC=0, DI=0, SEG=00, AN=0000, ERR=0, FRAME=0, regardless of LD.
REQ-023 SHALL, on the first edge after CDN returns high, drive AN=0001 and SEG=3F (digit 0 of H=0).
REQ-024 SHALL restart the scan from DI=0, PC=0 when reset is asserted mid-scan, with no partial-frame FRAME pulse.

Verification
REQ-025 Reset then LD with D=0x1234, PRESCALE=4 -> AN cycles 0001,0010,0100,1000 for 4 cycles each; SEG 66,4F,5B,06 on digits 0..3.
REQ-026 Free-running scan PRESCALE=4 -> FRAME high one cycle every 16 cycles, coincident with AN changing 1000->0001 on the next edge.
REQ-027 LD D=0x0007, BLANK_EN=1 -> digit 0 SEG=07, digits 1..3 SEG=00 with AN still one-hot; BLANK_EN=0 -> digits 1..3 SEG=3F.
REQ-028 LD D=0x00A5 -> ERR=1 next cycle; digit 1 SEG=40, digit 0 SEG=6D; subsequent LD D=0x0099 -> ERR=0.
REQ-029 CDN low for one cycle while DI=2 and LD=1 with D=0x5555 -> H=0000, AN=0000, SEG=00 next cycle; LD ignored; scan restarts at AN=0001.
REQ-030 PRESCALE=1, D=0x9876 -> AN changes every cycle, SEG 7D,07,7F,6F repeating, FRAME every 4th cycle.

Source files
------------

// File: rtl/bcd_scan4.sv
// bcd_scan4 -- four-digit multiplexed BCD display scanner.
//
// Latches a 16-bit packed-BCD value from upstream decade counters and scans
// it onto a common 7-segment bus, one digit at a time, each digit held for
// PRESCALE clock cycles.
//
// Parameters
//   PRESCALE  clock cycles each digit is displayed (1..65535)
//
// Ports
//   CLK       single clock, rising edge
//   CDN       synchronous active-low reset
//   LD        load strobe, samples D into the holding register
//   D[15:0]   four BCD digits, D[3:0] least significant
//   BLANK_EN  leading-zero blanking enable (live, not latched)
//   SEG[6:0]  registered segment drive, active-high, SEG[0]=a .. SEG[6]=g
//   AN[3:0]   registered digit select, active-high, one-hot or all-zero
//   ERR       high while the held value contains a non-BCD nibble
//   FRAME     one-cycle pulse after the last cycle of digit 3
module bcd_scan4 #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        CLK,
  input  logic        CDN,
  input  logic        LD,
  input  logic [15:0] D,
  input  logic        BLANK_EN,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        ERR,
  output logic        FRAME
);

  localparam logic [15:0] PC_LAST = 16'(PRESCALE - 1);

  // Segment patterns, bit 0 = a ... bit 6 = g. Non-BCD nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  function automatic logic has_bad_nibble(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  logic [15:0] h_q,     h_d;
  logic        err_q,   err_d;
  logic [15:0] pc_q,    pc_d;
  logic [1:0]  di_q,    di_d;
  logic        frame_q, frame_d;
  logic [3:0]  an_q,    an_d;
  logic [6:0]  seg_q,   seg_d;

  logic        pc_wrap;
  logic [3:0]  cur_nib;
  logic        lead_zero;

  always_comb begin
    h_d   = LD ? D : h_q;
    err_d = LD ? has_bad_nibble(D) : err_q;

    pc_wrap = (pc_q == PC_LAST);
    pc_d    = pc_wrap ? '0 : pc_q + 16'd1;
    di_d    = pc_wrap ? di_q + 2'd1 : di_q;
    frame_d = pc_wrap && (di_q == 2'd3);

    // Output stage works from pre-edge DI and H, so a load lands on SEG one
    // edge after the load edge at the earliest.
    an_d    = 4'b0001 << di_q;
    cur_nib = h_q[{di_q, 2'b00} +: 4];

    // A digit is a leading zero when it and every more significant nibble
    // are zero; digit 0 is always shown so the display never goes dark.
    case (di_q)
      2'd1:    lead_zero = (h_q[15:4]  == 12'h000);
      2'd2:    lead_zero = (h_q[15:8]  == 8'h00);
      2'd3:    lead_zero = (h_q[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase

    seg_d = (BLANK_EN && lead_zero) ? '0 : seg_decode(cur_nib);
  end

  always_ff @(posedge CLK) begin
    if (!CDN) begin
      h_q     <= '0;
      err_q   <= 1'b0;
      pc_q    <= '0;
      di_q    <= '0;
      frame_q <= 1'b0;
      an_q    <= '0;
      seg_q   <= '0;
    end else begin
      h_q     <= h_d;
      err_q   <= err_d;
      pc_q    <= pc_d;
      di_q    <= di_d;
      frame_q <= frame_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign ERR   = err_q;
  assign FRAME = frame_q;

endmodule
